// File: rtl/pipe_stage_reg_if.sv
// pipe_stage_reg_if: upstream/downstream bundle for a parametrised inter-stage pipeline register
interface pipe_stage_reg_if #(
    parameter int CTRL_W = 16,
    parameter int DATA_W = 128,
    parameter int STAGES = 1,
    parameter int CNT_W  = 16
);
    logic              Stall;
    logic [STAGES-1:0] Flush;
    logic              ValidIn;
    logic [CTRL_W-1:0] CtrlIn;
    logic [DATA_W-1:0] DataIn;
    logic              ValidOut;
    logic [CTRL_W-1:0] CtrlOut;
    logic [DATA_W-1:0] DataOut;
    logic [CNT_W-1:0]  StallCount;

    // hazard unit / upstream stage side
    modport master (
        output Stall, Flush, ValidIn, CtrlIn, DataIn,
        input  ValidOut, CtrlOut, DataOut, StallCount
    );

    // pipeline register side
    modport slave (
        input  Stall, Flush, ValidIn, CtrlIn, DataIn,
        output ValidOut, CtrlOut, DataOut, StallCount
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: STAGES-deep valid/ctrl/data register chain with stall, per-slice flush and stall counter
module pipe_stage_reg #(
    parameter int                CTRL_W      = 16,
    parameter int                DATA_W      = 128,
    parameter int                STAGES      = 1,
    parameter logic [CTRL_W-1:0] CTRL_BUBBLE = '0,
    parameter int                CNT_W       = 16
) (
    input logic            Clk,
    input logic            Rst_n,
    pipe_stage_reg_if.slave bus
);
    if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
        $error("pipe_stage_reg: STAGES must be in 1..4");
    end

    logic [STAGES-1:0]             valid_q, valid_d, src_v;
    logic [STAGES-1:0][CTRL_W-1:0] ctrl_q, ctrl_d, src_c;
    logic [STAGES-1:0][DATA_W-1:0] data_q, data_d, src_d;
    logic [CNT_W-1:0]              cnt_q, cnt_d;

    // slice 0 is fed by the input ports, slice k>0 by slice k-1
    if (STAGES == 1) begin : g_one
        assign src_v = bus.ValidIn;
        assign src_c = bus.CtrlIn;
        assign src_d = bus.DataIn;
    end else begin : g_many
        assign src_v = {valid_q[STAGES-2:0], bus.ValidIn};
        assign src_c = {ctrl_q[STAGES-2:0], bus.CtrlIn};
        assign src_d = {data_q[STAGES-2:0], bus.DataIn};
    end

    // per-slice priority: flush makes a bubble (data kept), else stall holds, else shift in
    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        data_d  = data_q;
        for (int k = 0; k < STAGES; k++) begin
            if (bus.Flush[k]) begin
                valid_d[k] = 1'b0;
                ctrl_d[k]  = CTRL_BUBBLE;
            end else if (!bus.Stall) begin
                valid_d[k] = src_v[k];
                ctrl_d[k]  = src_c[k];
                data_d[k]  = src_d[k];
            end
        end
    end

    // stall counter saturates at all-ones instead of wrapping
    always_comb cnt_d = (bus.Stall && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;

    // slice and counter state; reset drops everything in flight
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            valid_q <= '0;
            ctrl_q  <= {STAGES{CTRL_BUBBLE}};
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.ValidOut   = valid_q[STAGES-1];
    assign bus.CtrlOut    = ctrl_q[STAGES-1];
    assign bus.DataOut    = data_q[STAGES-1];
    assign bus.StallCount = cnt_q;
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed checks of pipe_stage_reg across 1..4 stage configurations
module tb_pipe_stage_reg;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipe_stage_reg_if #(.STAGES(1), .CNT_W(4)) b1 ();
    pipe_stage_reg_if #(.STAGES(2))            b2 ();
    pipe_stage_reg_if #(.STAGES(3))            b3 ();
    pipe_stage_reg_if #(.STAGES(4))            b4 ();

    pipe_stage_reg #(.STAGES(1), .CNT_W(4)) u1 (.Clk(clk), .Rst_n(rst_n), .bus(b1));
    pipe_stage_reg #(.STAGES(2))            u2 (.Clk(clk), .Rst_n(rst_n), .bus(b2));
    pipe_stage_reg #(.STAGES(3))            u3 (.Clk(clk), .Rst_n(rst_n), .bus(b3));
    pipe_stage_reg #(.STAGES(4))            u4 (.Clk(clk), .Rst_n(rst_n), .bus(b4));

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        b1.Stall = 0; b1.Flush = '0; b1.ValidIn = 0; b1.CtrlIn = '0; b1.DataIn = '0;
        b2.Stall = 0; b2.Flush = '0; b2.ValidIn = 0; b2.CtrlIn = '0; b2.DataIn = '0;
        b3.Stall = 0; b3.Flush = '0; b3.ValidIn = 0; b3.CtrlIn = '0; b3.DataIn = '0;
        b4.Stall = 0; b4.Flush = '0; b4.ValidIn = 0; b4.CtrlIn = '0; b4.DataIn = '0;
        #3;
        chk("rst_valid", 128'(b2.ValidOut), 128'd0);
        chk("rst_ctrl", 128'(b2.CtrlOut), 128'd0);
        chk("rst_data", b2.DataOut, 128'd0);
        chk("rst_cnt", 128'(b2.StallCount), 128'd0);
        step();
        rst_n = 1'b1;

        // latency through 3 slices
        b3.ValidIn = 1; b3.CtrlIn = 16'h00A5; b3.DataIn = 128'h1234;
        step();
        b3.ValidIn = 0; b3.CtrlIn = '0; b3.DataIn = '0;
        chk("lat_e1_valid", 128'(b3.ValidOut), 128'd0);
        step();
        chk("lat_e2_valid", 128'(b3.ValidOut), 128'd0);
        step();
        chk("lat_e3_valid", 128'(b3.ValidOut), 128'd1);
        chk("lat_e3_ctrl", 128'(b3.CtrlOut), 128'h00A5);
        chk("lat_e3_data", b3.DataOut, 128'h1234);
        step();
        chk("lat_e4_valid", 128'(b3.ValidOut), 128'd0);
        chk("lat_e4_ctrl", 128'(b3.CtrlOut), 128'd0);

        // asynchronous reset mid-operation
        b2.ValidIn = 1; b2.CtrlIn = 16'h0077; b2.DataIn = 128'h55;
        step();
        b2.ValidIn = 0; b2.CtrlIn = '0; b2.DataIn = '0; b2.Stall = 1;
        step();
        b2.Stall = 0;
        step();
        chk("pre_rst_valid", 128'(b2.ValidOut), 128'd1);
        chk("pre_rst_ctrl", 128'(b2.CtrlOut), 128'h0077);
        chk("pre_rst_data", b2.DataOut, 128'h55);
        chk("pre_rst_cnt", 128'(b2.StallCount), 128'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 128'(b2.ValidOut), 128'd0);
        chk("mid_rst_ctrl", 128'(b2.CtrlOut), 128'd0);
        chk("mid_rst_data", b2.DataOut, 128'd0);
        chk("mid_rst_cnt", 128'(b2.StallCount), 128'd0);
        step();
        rst_n = 1'b1;

        // stall holds a single slice
        b1.ValidIn = 1; b1.CtrlIn = 16'h0011;
        step();
        chk("stall_load", 128'(b1.CtrlOut), 128'h0011);
        b1.CtrlIn = 16'h0022; b1.Stall = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("stall_hold", 128'(b1.CtrlOut), 128'h0011);
        end
        b1.Stall = 0;
        chk("stall_cnt", 128'(b1.StallCount), 128'd4);
        step();
        chk("stall_release", 128'(b1.CtrlOut), 128'h0022);
        chk("stall_cnt_after", 128'(b1.StallCount), 128'd4);
        b1.ValidIn = 0; b1.CtrlIn = '0;

        // flush slice 1 while stalling
        b2.ValidIn = 1; b2.CtrlIn = 16'h0B0B; b2.DataIn = 128'hBBBB;
        step();
        b2.CtrlIn = 16'h0A0A; b2.DataIn = 128'hAAAA;
        step();
        chk("fs_pre_valid", 128'(b2.ValidOut), 128'd1);
        chk("fs_pre_ctrl", 128'(b2.CtrlOut), 128'h0B0B);
        b2.Stall = 1; b2.Flush = 2'b10; b2.CtrlIn = 16'h0C0C; b2.DataIn = 128'hCCCC;
        step();
        chk("fs_valid", 128'(b2.ValidOut), 128'd0);
        chk("fs_ctrl", 128'(b2.CtrlOut), 128'd0);
        chk("fs_data", b2.DataOut, 128'hBBBB);
        chk("fs_cnt", 128'(b2.StallCount), 128'd1);
        b2.Stall = 0; b2.Flush = '0; b2.ValidIn = 0; b2.CtrlIn = '0; b2.DataIn = '0;
        step();
        chk("fs_a_valid", 128'(b2.ValidOut), 128'd1);
        chk("fs_a_ctrl", 128'(b2.CtrlOut), 128'h0A0A);
        chk("fs_a_data", b2.DataOut, 128'hAAAA);

        // 4-bit counter saturation
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
        chk("sat_start", 128'(b1.StallCount), 128'd0);
        b1.Stall = 1;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (i == 14) chk("sat_14", 128'(b1.StallCount), 128'd14);
            if (i == 15) chk("sat_15", 128'(b1.StallCount), 128'd15);
        end
        chk("sat_20", 128'(b1.StallCount), 128'd15);
        b1.Stall = 0;

        // flush all four slices at once
        for (int i = 0; i < 4; i++) begin
            b4.ValidIn = 1; b4.CtrlIn = 16'(i + 1); b4.DataIn = 128'(i + 'h100);
            step();
        end
        chk("fa_full_valid", 128'(b4.ValidOut), 128'd1);
        chk("fa_full_ctrl", 128'(b4.CtrlOut), 128'h1);
        chk("fa_full_data", b4.DataOut, 128'h100);
        b4.ValidIn = 0; b4.CtrlIn = '0; b4.DataIn = '0; b4.Flush = 4'hF;
        step();
        chk("fa_valid", 128'(b4.ValidOut), 128'd0);
        chk("fa_ctrl", 128'(b4.CtrlOut), 128'd0);
        chk("fa_data", b4.DataOut, 128'h100);
        b4.Flush = '0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("fa_bubble", 128'(b4.ValidOut), 128'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
